// File: rtl/mem_arbiter.sv
// Shared-memory arbiter for I-cache reads, D-cache reads and D-cache writebacks.
// One transaction at a time: grant in IDLE, hold mem_req until mem_ready or timeout, pulse in RESP.
module mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              reqD_mem,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic              reqD_cache_write,
    input  logic [ADDR_W-1:0] reqAddrD_write_mem,
    input  logic [LINE_W-1:0] data_to_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] data_from_mem,
    output logic              read_ready_I,
    output logic              read_ready_D,
    output logic              written_data_ack,
    output logic              arb_busy,
    output logic              mem_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ_D = 3'd2,
        S_READ_I = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t state_q, state_d;
    state_t op_q, op_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              lru_q, lru_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tmo_q, tmo_d;

    logic       grant_w, grant_d, grant_i, grant;
    logic       done, expire;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;
    assign grant   = grant_w | grant_d | grant_i;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lru_q = 1 means D won the most recent read grant, so a tie goes to I.
    always_comb begin
        state_d = state_q;
        grant_w = 1'b0;
        grant_d = 1'b0;
        grant_i = 1'b0;
        done    = 1'b0;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reqD_cache_write) begin
                    state_d = S_WRITE;
                    grant_w = 1'b1;
                end else if (reqD_mem && (!reqI_mem || !lru_q)) begin
                    state_d = S_READ_D;
                    grant_d = 1'b1;
                end else if (reqI_mem) begin
                    state_d = S_READ_I;
                    grant_i = 1'b1;
                end
            end
            S_WRITE, S_READ_D, S_READ_I: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                    done    = 1'b1;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = S_IDLE;
                    expire  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the operation latched at grant
    always_comb begin
        arb_busy         = (state_q != S_IDLE);
        read_ready_I     = (state_q == S_RESP) && (op_q == S_READ_I);
        read_ready_D     = (state_q == S_RESP) && (op_q == S_READ_D);
        written_data_ack = (state_q == S_RESP) && (op_q == S_WRITE);
    end

    always_comb begin
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        lru_d       = lru_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;

        if (grant) begin
            op_d      = state_d;
            mem_req_d = 1'b1;
            mem_we_d  = grant_w;
            cnt_d     = 8'd0;
            if (grant_w) begin
                mem_addr_d  = reqAddrD_write_mem;
                mem_wdata_d = data_to_mem;
            end else if (grant_d) begin
                mem_addr_d = reqAddrD_mem;
                lru_d      = 1'b1;
            end else begin
                mem_addr_d = reqAddrI_mem;
                lru_d      = 1'b0;
            end
        end

        if (done) begin
            mem_req_d = 1'b0;
            if (op_q != S_WRITE) begin
                rdata_d = mem_rdata;
            end
        end else if (expire) begin
            mem_req_d = 1'b0;
            tmo_d     = 1'b1;
            cnt_d     = cnt_inc;
        end else if (state_q == S_WRITE || state_q == S_READ_D || state_q == S_READ_I) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            lru_q       <= 1'b0;
            cnt_q       <= 8'd0;
            tmo_q       <= 1'b0;
        end else begin
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            lru_q       <= lru_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign data_from_mem = rdata_q;
    assign mem_timeout   = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and a memory model drive the DUT,
// an order model predicts service sequence, a monitor checks each ready/ack pulse.
module tb_mem_arbiter;

    localparam int ADDR_W  = 20;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 255;
    localparam int K_W = 0;
    localparam int K_D = 1;
    localparam int K_I = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI_mem, reqD_mem, reqD_cache_write;
    logic [ADDR_W-1:0] reqAddrI_mem, reqAddrD_mem, reqAddrD_write_mem;
    logic [LINE_W-1:0] data_to_mem;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic [LINE_W-1:0] data_from_mem;
    logic              read_ready_I, read_ready_D, written_data_ack;
    logic              arb_busy, mem_timeout;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .reqD_mem(reqD_mem), .reqAddrD_mem(reqAddrD_mem),
        .reqD_cache_write(reqD_cache_write), .reqAddrD_write_mem(reqAddrD_write_mem),
        .data_to_mem(data_to_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .data_from_mem(data_from_mem),
        .read_ready_I(read_ready_I), .read_ready_D(read_ready_D),
        .written_data_ack(written_data_ack),
        .arb_busy(arb_busy), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   last_d = 1'b0;   // model: most recent read grant went to D

    // memory model state
    bit                mem_hold = 1'b0;
    int                lat_min = 0, lat_max = 5, wait_cnt = 0;
    logic [ADDR_W-1:0] obs_addr;
    logic              obs_we;
    logic [LINE_W-1:0] obs_wdata;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        if (a == 20'h00040) return {16{8'hA5}};
        return {12'h9A5, a, 12'h3C1, ~a, 12'h777, a ^ 20'hF0F0F, 12'h0DE, a + 20'd1};
    endfunction

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory: answers mem_req after a random delay with the line stored at that address
    always begin
        @(negedge clk);
        mem_ready = 1'b0;
        if (mem_req && !mem_hold) begin
            if (wait_cnt <= 0) begin
                mem_ready = 1'b1;
                mem_rdata = line_of(mem_addr);
                obs_addr  = mem_addr;
                obs_we    = mem_we;
                obs_wdata = mem_wdata;
                wait_cnt  = $urandom_range(lat_max, lat_min);
            end else begin
                wait_cnt--;
            end
        end
    end

    // Monitor: every ready/ack pulse retires the oldest expected transaction
    int   mk;
    exp_t me;
    always @(negedge clk) begin
        if (read_ready_I || read_ready_D || written_data_ack) begin
            chk("pulse onehot", 128'(int'(read_ready_I) + int'(read_ready_D) + int'(written_data_ack)), 128'd1);
            mk = written_data_ack ? K_W : (read_ready_D ? K_D : K_I);
            if (exp_q.size() == 0) begin
                chk("pending count at pulse", 128'(exp_q.size()), 128'd1);
            end else begin
                me = exp_q.pop_front();
                chk("served kind", 128'(mk), 128'(me.kind));
                chk("mem addr", 128'(obs_addr), 128'(me.addr));
                chk("mem we", 128'(obs_we), 128'(me.kind == K_W));
                if (me.kind == K_W) chk("write data", obs_wdata, me.wdata);
                else chk("read line", data_from_mem, line_of(me.addr));
            end
        end
    end

    task automatic push(input int k, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
        exp_t e;
        e.kind = k; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Order model: writeback first, then reads; a read tie goes to the side not served last
    task automatic model_batch(input bit w, input bit d, input bit i,
                               input logic [ADDR_W-1:0] aw, input logic [ADDR_W-1:0] ad,
                               input logic [ADDR_W-1:0] ai, input logic [LINE_W-1:0] wd);
        if (w) push(K_W, aw, wd);
        if (d && i) begin
            if (last_d) begin push(K_I, ai, '0); push(K_D, ad, '0); last_d = 1'b1; end
            else        begin push(K_D, ad, '0); push(K_I, ai, '0); last_d = 1'b0; end
        end else if (d) begin
            push(K_D, ad, '0); last_d = 1'b1;
        end else if (i) begin
            push(K_I, ai, '0); last_d = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (arb_busy && n < 100) begin @(negedge clk); n++; end
        chk("idle before batch", 128'(arb_busy), 128'd0);
    endtask

    task automatic run_batch(input bit w, input bit d, input bit i,
                             input logic [ADDR_W-1:0] aw, input logic [ADDR_W-1:0] ad,
                             input logic [ADDR_W-1:0] ai, input logic [LINE_W-1:0] wd);
        int n;
        logic [ADDR_W-1:0] first_addr;
        logic              first_we;
        if (!(w || d || i)) return;
        wait_idle();
        model_batch(w, d, i, aw, ad, ai, wd);
        first_addr = exp_q[0].addr;
        first_we   = (exp_q[0].kind == K_W);
        reqD_cache_write = w; reqAddrD_write_mem = aw; data_to_mem = wd;
        reqD_mem = d; reqAddrD_mem = ad;
        reqI_mem = i; reqAddrI_mem = ai;
        @(negedge clk);
        chk("mem_req one cycle after request", 128'(mem_req), 128'd1);
        chk("granted addr", 128'(mem_addr), 128'(first_addr));
        chk("granted we", 128'(mem_we), 128'(first_we));
        n = 0;
        while (n < 2000) begin
            if (read_ready_I) reqI_mem = 1'b0;
            if (read_ready_D) reqD_mem = 1'b0;
            if (written_data_ack) reqD_cache_write = 1'b0;
            if (!(reqI_mem || reqD_mem || reqD_cache_write)) break;
            @(negedge clk);
            n++;
        end
        chk("batch drained", 128'({reqD_cache_write, reqD_mem, reqI_mem}), 128'd0);
        reqD_cache_write = 1'b0; reqD_mem = 1'b0; reqI_mem = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        reqI_mem = 0; reqD_mem = 0; reqD_cache_write = 0;
        reqAddrI_mem = '0; reqAddrD_mem = '0; reqAddrD_write_mem = '0; data_to_mem = '0;
        mem_ready = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset mem_req", 128'(mem_req), 128'd0);
        chk("reset mem_we", 128'(mem_we), 128'd0);
        chk("reset arb_busy", 128'(arb_busy), 128'd0);
        chk("reset mem_timeout", 128'(mem_timeout), 128'd0);
        chk("reset data_from_mem", data_from_mem, '0);
        chk("reset mem_addr", 128'(mem_addr), 128'd0);
        chk("reset pulses", 128'({read_ready_I, read_ready_D, written_data_ack}), 128'd0);
        reset = 1'b0;

        // Single I read with fixed latency, granted on the first edge after reset
        lat_min = 2; lat_max = 2; wait_cnt = 2;
        run_batch(0, 0, 1, '0, '0, 20'h00040, '0);
        lat_min = 0; lat_max = 5;

        // Read ties: D-first after an I grant, then I-first after a D grant
        run_batch(0, 1, 1, '0, 20'h00111, 20'h00222, '0);
        run_batch(0, 1, 0, '0, 20'h00333, '0, '0);
        run_batch(0, 1, 1, '0, 20'h00444, 20'h00555, '0);

        // Writeback wins over a simultaneous read
        run_batch(1, 1, 0, 20'h00100, 20'h00200, '0, {4{32'hDEADBEEF}});

        for (int k = 0; k < 40; k++) begin
            run_batch(1'($urandom), 1'($urandom), 1'($urandom),
                      20'($urandom), 20'($urandom), 20'($urandom),
                      {$urandom, $urandom, $urandom, $urandom});
        end

        // Timeout: memory withholds mem_ready, then the request is re-granted and completes
        wait_idle();
        mem_hold = 1'b1;
        model_batch(0, 0, 1, '0, '0, 20'h00055, '0);
        reqI_mem = 1'b1; reqAddrI_mem = 20'h00055;
        n = 0;
        while (!mem_req && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (mem_req && n < 400) begin n++; @(negedge clk); end
        chk("timeout mem_req cycles", 128'(n), 128'(TIMEOUT));
        chk("timeout flag set", 128'(mem_timeout), 128'd1);
        chk("idle after timeout", 128'(arb_busy), 128'd0);
        mem_hold = 1'b0;
        n = 0;
        while (!read_ready_I && n < 100) begin @(negedge clk); n++; end
        reqI_mem = 1'b0;
        chk("regrant completes", 128'(n < 100), 128'd1);
        repeat (3) @(negedge clk);
        chk("timeout flag sticky", 128'(mem_timeout), 128'd1);

        // Asynchronous reset in the middle of a read
        wait_idle();
        mem_hold = 1'b1;
        reqD_mem = 1'b1; reqAddrD_mem = 20'h00321;
        @(negedge clk);
        chk("mem_req before reset", 128'(mem_req), 128'd1);
        #3 reset = 1'b1;
        #1;
        chk("async reset mem_req", 128'(mem_req), 128'd0);
        chk("async reset arb_busy", 128'(arb_busy), 128'd0);
        chk("async reset mem_timeout", 128'(mem_timeout), 128'd0);
        chk("async reset data_from_mem", data_from_mem, '0);
        chk("async reset mem_addr", 128'(mem_addr), 128'd0);
        reqD_mem = 1'b0;
        mem_hold = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("no pulse after reset release", 128'(exp_q.size()), 128'd0);

        // lru cleared: tie goes to D first
        run_batch(0, 1, 1, '0, 20'h00666, 20'h00777, '0);
        repeat (4) @(negedge clk);
        chk("scoreboard empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
